// File: rtl/net_eject_if_pkg.sv
// Shared widths, flit field layout and mesh size for the ejection-side network interface.
// Flit layout is {dest_x, dest_y, payload}, MSB first.
package net_eject_if_pkg;

    localparam int FIFO_DEPTH = 4;
    localparam int COORD_W    = 16;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 8;

    localparam int FLIT_W     = 64;
    localparam int FLIT_X_HI  = 63;
    localparam int FLIT_X_LO  = 48;
    localparam int FLIT_Y_HI  = 47;
    localparam int FLIT_Y_LO  = 32;
    localparam int FLIT_D_HI  = 31;
    localparam int FLIT_D_LO  = 0;

    localparam int MESH_X     = 3;
    localparam int MESH_Y     = 3;

    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    function automatic logic flit_is_local(input logic [FLIT_W-1:0]  flit,
                                           input logic [COORD_W-1:0] x,
                                           input logic [COORD_W-1:0] y);
        return (flit[FLIT_X_HI:FLIT_X_LO] == x) && (flit[FLIT_Y_HI:FLIT_Y_LO] == y);
    endfunction

    function automatic logic [DATA_W-1:0] flit_payload(input logic [FLIT_W-1:0] flit);
        return flit[FLIT_D_HI:FLIT_D_LO];
    endfunction

endpackage

// File: rtl/net_eject_if_if.sv
// Router-to-node flit handshake plus node-CPU read handshake.
// The master drives flits and reads; the slave is the ejection interface.
interface net_eject_if_if;
    import net_eject_if_pkg::*;

    logic [FLIT_W-1:0] flit_in;
    logic              flit_valid;
    logic              flit_ready;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_valid;
    logic              cpu_rd;

    modport master (
        output flit_in, flit_valid, cpu_rd,
        input  flit_ready, cpu_data, cpu_valid
    );

    modport slave (
        input  flit_in, flit_valid, cpu_rd,
        output flit_ready, cpu_data, cpu_valid
    );

endinterface

// File: rtl/net_sync_fifo.sv
// Payload FIFO with first-word-fall-through head held in a register (0 when empty).
// Level is a separate up/down counter; pointers wrap naturally.
module net_sync_fifo
    import net_eject_if_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [LVL_W-1:0]  level,
    output logic [DATA_W-1:0] head,
    output logic              head_valid
);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [LVL_W-1:0]  level_q, level_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              valid_q, valid_d;
    logic              do_push, do_pop;

    assign do_push    = push & (level_q != FULL_LVL);
    assign do_pop     = pop & (level_q != '0);
    assign rd_ptr_nxt = rd_ptr_q + PTR_W'(1);

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_nxt : rd_ptr_q;
        level_d  = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
        // The next head may be the word being written this edge, which is not in mem_q yet.
        head_d = head_q;
        if (do_pop) begin
            if (level_q > LVL_W'(1)) begin
                head_d = mem_q[rd_ptr_nxt];
            end else if (do_push) begin
                head_d = push_data;
            end else begin
                head_d = '0;
            end
        end else if ((level_q == '0) && do_push) begin
            head_d = push_data;
        end
        valid_d = (level_d != '0);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign level      = level_q;
    assign head       = head_q;
    assign head_valid = valid_q;

endmodule

// File: rtl/net_eject_if.sv
// Ejection interface: destination check, payload buffering toward the CPU,
// saturating misroute counter and sticky underflow flag.
module net_eject_if
    import net_eject_if_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] my_x,
    input  logic [COORD_W-1:0] my_y,
    net_eject_if_if.slave      bus,
    output logic [LVL_W-1:0]   fifo_level,
    output logic [CNT_W-1:0]   misroute_cnt,
    output logic               err_underflow
);

    logic             accept, is_local, push, pop;
    logic [CNT_W-1:0] mis_q, mis_d;
    logic             under_q, under_d;

    // Ready depends only on registered level, so a full FIFO stalls even during a pop.
    assign bus.flit_ready = rst & (fifo_level < FULL_LVL);

    assign accept   = bus.flit_valid & bus.flit_ready;
    assign is_local = flit_is_local(bus.flit_in, my_x, my_y);
    assign push     = accept & is_local;
    assign pop      = bus.cpu_rd & bus.cpu_valid;

    always_comb begin
        mis_d = mis_q;
        if (accept && !is_local && (mis_q != '1)) begin
            mis_d = mis_q + CNT_W'(1);
        end
        under_d = under_q | (bus.cpu_rd & ~bus.cpu_valid);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mis_q   <= '0;
            under_q <= 1'b0;
        end else begin
            mis_q   <= mis_d;
            under_q <= under_d;
        end
    end

    net_sync_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_data  (flit_payload(bus.flit_in)),
        .pop        (pop),
        .level      (fifo_level),
        .head       (bus.cpu_data),
        .head_valid (bus.cpu_valid)
    );

    assign misroute_cnt  = mis_q;
    assign err_underflow = under_q;

endmodule
